// File: rtl/level_progress_tracker.sv
// Per-level goal/coin tracker: watches the player against the active level's goal box and coin,
// handles enemy hits (respawn hold, coin loss, death count) and raises the End/Coin flags.
module level_progress_tracker #(
   parameter int unsigned GOAL_HOLD   = 8,
   parameter int unsigned RESPAWN_CYC = 60,
   parameter int unsigned COIN_REACH  = 8
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        Level1_Active,
   input  logic        Level2_Active,
   input  logic        Level3_Active,
   input  logic [9:0]  PlayerX,
   input  logic [9:0]  PlayerY,
   input  logic        Player_Hit,
   input  logic [9:0]  Goal_X0,
   input  logic [9:0]  Goal_X1,
   input  logic [9:0]  Goal_Y0,
   input  logic [9:0]  Goal_Y1,
   input  logic [9:0]  Coin_X,
   input  logic [9:0]  Coin_Y,
   output logic        Level1_End,
   output logic        Level2_End,
   output logic        Level3_End,
   output logic        CoinCollected_Level2,
   output logic        CoinCollected_Level3,
   output logic        Respawn,
   output logic [15:0] Death_Count
);

   localparam int unsigned GW = $clog2(GOAL_HOLD + 1);
   localparam int unsigned DW = (RESPAWN_CYC > 1) ? $clog2(RESPAWN_CYC) : 1;

   typedef enum logic [1:0] {StIdle, StPlay, StDead, StDone} state_e;

   state_e          state_q, state_d;
   logic [1:0]      lvl_q, lvl_d;
   logic [GW-1:0]   goal_cnt_q, goal_cnt_d;
   logic [DW-1:0]   dead_cnt_q, dead_cnt_d;
   logic            coin_q, coin_d;
   logic            respawn_q, respawn_d;
   logic [15:0]     death_cnt_q, death_cnt_d;

   logic            any_active;
   logic            lvl_active;
   logic            in_goal;
   logic            goal_ok;
   logic            coin_near;
   logic signed [10:0] dx, dy;
   logic [10:0]     adx, ady;
   logic [15:0]     death_inc;

   assign any_active = Level1_Active | Level2_Active | Level3_Active;

   always_comb begin
      unique case (lvl_q)
         2'd1:    lvl_active = Level1_Active;
         2'd2:    lvl_active = Level2_Active;
         default: lvl_active = Level3_Active;
      endcase
   end

   assign in_goal = (PlayerX >= Goal_X0) && (PlayerX <= Goal_X1) &&
                    (PlayerY >= Goal_Y0) && (PlayerY <= Goal_Y1);

   // In levels 2 and 3 the goal only counts once the coin is already held.
   assign goal_ok = in_goal && ((lvl_q == 2'd1) || coin_q);

   // Zero-extended 11-bit signed differences, so coordinates near 0 never wrap.
   assign dx  = $signed({1'b0, PlayerX}) - $signed({1'b0, Coin_X});
   assign dy  = $signed({1'b0, PlayerY}) - $signed({1'b0, Coin_Y});
   assign adx = dx[10] ? 11'(-dx) : 11'(dx);
   assign ady = dy[10] ? 11'(-dy) : 11'(dy);

   assign coin_near = (lvl_q != 2'd1) && (adx <= 11'(COIN_REACH)) && (ady <= 11'(COIN_REACH));

   assign death_inc = (death_cnt_q == 16'hFFFF) ? death_cnt_q : death_cnt_q + 16'd1;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= StIdle;
         lvl_q       <= 2'd1;
         goal_cnt_q  <= '0;
         dead_cnt_q  <= '0;
         coin_q      <= 1'b0;
         respawn_q   <= 1'b0;
         death_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         lvl_q       <= lvl_d;
         goal_cnt_q  <= goal_cnt_d;
         dead_cnt_q  <= dead_cnt_d;
         coin_q      <= coin_d;
         respawn_q   <= respawn_d;
         death_cnt_q <= death_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      lvl_d       = lvl_q;
      goal_cnt_d  = goal_cnt_q;
      dead_cnt_d  = dead_cnt_q;
      coin_d      = coin_q;
      respawn_d   = 1'b0;
      death_cnt_d = death_cnt_q;

      unique case (state_q)
         StIdle: begin
            if (any_active) begin
               state_d    = StPlay;
               lvl_d      = Level1_Active ? 2'd1 : (Level2_Active ? 2'd2 : 2'd3);
               goal_cnt_d = '0;
               coin_d     = 1'b0;
            end
         end
         StPlay: begin
            if (!lvl_active) begin
               state_d    = StIdle;
               goal_cnt_d = '0;
               coin_d     = 1'b0;
            end else if (Player_Hit) begin
               // A hit overrides any goal or coin event in the same cycle.
               state_d     = StDead;
               goal_cnt_d  = '0;
               dead_cnt_d  = '0;
               coin_d      = 1'b0;
               death_cnt_d = death_inc;
            end else begin
               if (goal_ok) begin
                  goal_cnt_d = goal_cnt_q + GW'(1);
                  if (goal_cnt_q == GW'(GOAL_HOLD - 1)) begin
                     state_d = StDone;
                  end
               end else begin
                  goal_cnt_d = '0;
               end
               if (coin_near) begin
                  coin_d = 1'b1;
               end
            end
         end
         StDead: begin
            if (!lvl_active) begin
               state_d    = StIdle;
               goal_cnt_d = '0;
               coin_d     = 1'b0;
            end else if (dead_cnt_q == DW'(RESPAWN_CYC - 1)) begin
               state_d    = StPlay;
               dead_cnt_d = '0;
               respawn_d  = 1'b1;
            end else begin
               dead_cnt_d = dead_cnt_q + DW'(1);
            end
         end
         StDone: begin
            if (!lvl_active) begin
               state_d    = StIdle;
               goal_cnt_d = '0;
               coin_d     = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      Level1_End           = (state_q == StDone) && (lvl_q == 2'd1);
      Level2_End           = (state_q == StDone) && (lvl_q == 2'd2);
      Level3_End           = (state_q == StDone) && (lvl_q == 2'd3);
      CoinCollected_Level2 = coin_q && (lvl_q == 2'd2);
      CoinCollected_Level3 = coin_q && (lvl_q == 2'd3);
      Respawn              = respawn_q;
      Death_Count          = death_cnt_q;
   end

endmodule

// File: tb/tb_level_progress_tracker.sv
// Bench for level_progress_tracker: directed scenarios plus a randomized run checked against
// a cycle-level behavioural model of the level rules.
module tb_level_progress_tracker;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        Level1_Active, Level2_Active, Level3_Active;
   logic [9:0]  PlayerX, PlayerY;
   logic        Player_Hit;
   logic [9:0]  Goal_X0, Goal_X1, Goal_Y0, Goal_Y1;
   logic [9:0]  Coin_X, Coin_Y;
   logic        Level1_End, Level2_End, Level3_End;
   logic        CoinCollected_Level2, CoinCollected_Level3;
   logic        Respawn;
   logic [15:0] Death_Count;

   int total = 0;
   int bad   = 0;
   int exp_deaths = 0;

   // Model state: 0 idle, 1 play, 2 dead, 3 done.
   int m_state, m_lvl, m_goal, m_dead, m_deaths;
   bit m_coin, m_resp;

   level_progress_tracker dut (
      .Clk                  (Clk),
      .Reset_n              (Reset_n),
      .Level1_Active        (Level1_Active),
      .Level2_Active        (Level2_Active),
      .Level3_Active        (Level3_Active),
      .PlayerX              (PlayerX),
      .PlayerY              (PlayerY),
      .Player_Hit           (Player_Hit),
      .Goal_X0              (Goal_X0),
      .Goal_X1              (Goal_X1),
      .Goal_Y0              (Goal_Y0),
      .Goal_Y1              (Goal_Y1),
      .Coin_X               (Coin_X),
      .Coin_Y               (Coin_Y),
      .Level1_End           (Level1_End),
      .Level2_End           (Level2_End),
      .Level3_End           (Level3_End),
      .CoinCollected_Level2 (CoinCollected_Level2),
      .CoinCollected_Level3 (CoinCollected_Level3),
      .Respawn              (Respawn),
      .Death_Count          (Death_Count)
   );

   always #5 Clk = ~Clk;

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic set_pos(input int x, input int y);
      PlayerX = 10'(x);
      PlayerY = 10'(y);
   endtask

   task automatic go_idle();
      Level1_Active = 1'b0;
      Level2_Active = 1'b0;
      Level3_Active = 1'b0;
      Player_Hit    = 1'b0;
      set_pos(600, 600);
      cyc();
      cyc();
   endtask

   function automatic logic [9:0] clamp10(input int v);
      if (v < 0) return 10'd0;
      if (v > 1023) return 10'd1023;
      return 10'(v);
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   task automatic test_reset();
      Reset_n = 1'b0;
      Level1_Active = 1'b0; Level2_Active = 1'b0; Level3_Active = 1'b0;
      Player_Hit = 1'b0;
      Goal_X0 = 10'd100; Goal_X1 = 10'd120; Goal_Y0 = 10'd100; Goal_Y1 = 10'd120;
      Coin_X = 10'd300; Coin_Y = 10'd300;
      set_pos(600, 600);
      #3;
      total++;
      if ({Level1_End, Level2_End, Level3_End, CoinCollected_Level2, CoinCollected_Level3, Respawn}
          !== 6'b0) begin
         bad++;
         $display("FAIL reset_flags: got %b want 000000", {Level1_End, Level2_End, Level3_End,
                  CoinCollected_Level2, CoinCollected_Level3, Respawn});
      end
      total++;
      if (Death_Count !== 16'd0) begin
         bad++; $display("FAIL reset_deaths: got %0d want 0", Death_Count);
      end
      @(negedge Clk);
      Reset_n = 1'b1;
      exp_deaths = 0;
      cyc();
      total++;
      if ({Level1_End, Level2_End, Level3_End, Respawn} !== 4'b0) begin
         bad++; $display("FAIL reset_release: flags %b want 0000",
                         {Level1_End, Level2_End, Level3_End, Respawn});
      end
   endtask

   task automatic test_l1_goal();
      set_pos(110, 110);
      Level1_Active = 1'b1;
      cyc();
      for (int k = 1; k <= 8; k++) begin
         cyc();
         total++;
         if (Level1_End !== (k == 8)) begin
            bad++; $display("FAIL l1_goal edge%0d: Level1_End=%b want %b", k, Level1_End, k == 8);
         end
      end
      total++;
      if ({Level2_End, Level3_End} !== 2'b00) begin
         bad++; $display("FAIL l1_other_ends: got %b want 00", {Level2_End, Level3_End});
      end
      Level1_Active = 1'b0;
      cyc();
      total++;
      if (Level1_End !== 1'b0) begin
         bad++; $display("FAIL l1_exit: Level1_End=%b want 0", Level1_End);
      end
      go_idle();
   endtask

   task automatic test_l2_coin();
      logic seen;
      set_pos(110, 110);
      Level2_Active = 1'b1;
      cyc();
      seen = 1'b0;
      repeat (50) begin
         cyc();
         seen |= Level2_End;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++; $display("FAIL l2_no_coin_end: Level2_End seen=%b want 0", seen);
      end
      set_pos(308, 292);
      cyc();
      total++;
      if ({CoinCollected_Level2, CoinCollected_Level3} !== 2'b10) begin
         bad++; $display("FAIL l2_coin_pick: coin2/3=%b want 10",
                         {CoinCollected_Level2, CoinCollected_Level3});
      end
      set_pos(110, 110);
      for (int k = 1; k <= 8; k++) begin
         cyc();
         total++;
         if (Level2_End !== (k == 8)) begin
            bad++; $display("FAIL l2_goal edge%0d: Level2_End=%b want %b", k, Level2_End, k == 8);
         end
      end
      total++;
      if (CoinCollected_Level2 !== 1'b1) begin
         bad++; $display("FAIL l2_coin_in_done: got %b want 1", CoinCollected_Level2);
      end
      Level2_Active = 1'b0;
      cyc();
      total++;
      if ({Level2_End, CoinCollected_Level2} !== 2'b00) begin
         bad++; $display("FAIL l2_exit: end/coin=%b want 00", {Level2_End, CoinCollected_Level2});
      end
      go_idle();
   endtask

   task automatic test_coin_reach();
      Coin_X = 10'd300; Coin_Y = 10'd300;
      set_pos(309, 300);
      Level2_Active = 1'b1;
      cyc();
      repeat (3) cyc();
      total++;
      if (CoinCollected_Level2 !== 1'b0) begin
         bad++; $display("FAIL reach_plus9: coin2=%b want 0", CoinCollected_Level2);
      end
      set_pos(292, 300);
      cyc();
      total++;
      if (CoinCollected_Level2 !== 1'b1) begin
         bad++; $display("FAIL reach_minus8: coin2=%b want 1", CoinCollected_Level2);
      end
      go_idle();
      Coin_X = 10'd3;
      set_pos(0, 300);
      Level2_Active = 1'b1;
      cyc();
      total++;
      if (CoinCollected_Level2 !== 1'b0) begin
         bad++; $display("FAIL reach_entry_clear: coin2=%b want 0", CoinCollected_Level2);
      end
      cyc();
      total++;
      if (CoinCollected_Level2 !== 1'b1) begin
         bad++; $display("FAIL reach_nowrap: coin2=%b want 1", CoinCollected_Level2);
      end
      go_idle();
      Coin_X = 10'd300;
   endtask

   task automatic test_hit();
      logic seen;
      set_pos(300, 300);
      Level3_Active = 1'b1;
      cyc();
      cyc();
      total++;
      if (CoinCollected_Level3 !== 1'b1) begin
         bad++; $display("FAIL hit_coin_pre: coin3=%b want 1", CoinCollected_Level3);
      end
      Player_Hit = 1'b1;
      cyc();
      Player_Hit = 1'b0;
      exp_deaths++;
      total++;
      if (CoinCollected_Level3 !== 1'b0 || Death_Count !== 16'(exp_deaths)) begin
         bad++; $display("FAIL hit_effect: coin3=%b deaths=%0d want 0/%0d",
                         CoinCollected_Level3, Death_Count, exp_deaths);
      end
      set_pos(600, 600);
      seen = 1'b0;
      for (int i = 1; i <= 59; i++) begin
         Player_Hit = (i == 10);
         cyc();
         seen |= Respawn;
      end
      Player_Hit = 1'b0;
      total++;
      if (seen !== 1'b0 || Death_Count !== 16'(exp_deaths)) begin
         bad++; $display("FAIL hit_dead_hold: respawn_seen=%b deaths=%0d want 0/%0d",
                         seen, Death_Count, exp_deaths);
      end
      cyc();
      total++;
      if (Respawn !== 1'b1) begin
         bad++; $display("FAIL hit_respawn: Respawn=%b want 1", Respawn);
      end
      cyc();
      total++;
      if (Respawn !== 1'b0) begin
         bad++; $display("FAIL hit_respawn_pulse: Respawn=%b want 0", Respawn);
      end
   endtask

   task automatic test_back_to_back();
      logic seen;
      Player_Hit = 1'b1;
      cyc();
      exp_deaths++;
      seen = 1'b0;
      repeat (59) begin
         cyc();
         seen |= Respawn;
      end
      total++;
      if (seen !== 1'b0 || Death_Count !== 16'(exp_deaths)) begin
         bad++; $display("FAIL b2b_dead: respawn_seen=%b deaths=%0d want 0/%0d",
                         seen, Death_Count, exp_deaths);
      end
      cyc();
      total++;
      if (Respawn !== 1'b1 || Death_Count !== 16'(exp_deaths)) begin
         bad++; $display("FAIL b2b_respawn: Respawn=%b deaths=%0d want 1/%0d",
                         Respawn, Death_Count, exp_deaths);
      end
      cyc();
      exp_deaths++;
      total++;
      if (Respawn !== 1'b0 || Death_Count !== 16'(exp_deaths)) begin
         bad++; $display("FAIL b2b_rehit: Respawn=%b deaths=%0d want 0/%0d",
                         Respawn, Death_Count, exp_deaths);
      end
      go_idle();
   endtask

   task automatic test_simultaneous();
      set_pos(110, 110);
      Level1_Active = 1'b1;
      cyc();
      repeat (7) cyc();
      Player_Hit = 1'b1;
      cyc();
      Player_Hit = 1'b0;
      exp_deaths++;
      cyc();
      total++;
      if (Level1_End !== 1'b0 || Death_Count !== 16'(exp_deaths)) begin
         bad++; $display("FAIL simul_hit_goal: end=%b deaths=%0d want 0/%0d",
                         Level1_End, Death_Count, exp_deaths);
      end
      go_idle();
      Level1_Active = 1'b1;
      cyc();
      force dut.death_cnt_q = 16'hFFFF;
      cyc();
      release dut.death_cnt_q;
      exp_deaths = 16'hFFFF;
      Player_Hit = 1'b1;
      cyc();
      Player_Hit = 1'b0;
      total++;
      if (Death_Count !== 16'hFFFF) begin
         bad++; $display("FAIL saturate: deaths=%h want ffff", Death_Count);
      end
      go_idle();
   endtask

   task automatic test_async_reset();
      set_pos(110, 110);
      Level1_Active = 1'b1;
      cyc();
      repeat (8) cyc();
      total++;
      if (Level1_End !== 1'b1) begin
         bad++; $display("FAIL areset_pre_done: end=%b want 1", Level1_End);
      end
      #2;
      Reset_n = 1'b0;
      Level1_Active = 1'b0;
      #1;
      exp_deaths = 0;
      total++;
      if ({Level1_End, Level2_End, Level3_End, CoinCollected_Level2, CoinCollected_Level3, Respawn}
          !== 6'b0 || Death_Count !== 16'd0) begin
         bad++; $display("FAIL areset_immediate: flags=%b deaths=%0d want 0/0",
                         {Level1_End, Level2_End, Level3_End, CoinCollected_Level2,
                          CoinCollected_Level3, Respawn}, Death_Count);
      end
      @(negedge Clk);
      Reset_n = 1'b1;
      cyc();
      Level1_Active = 1'b1;
      cyc();
      for (int k = 1; k <= 8; k++) begin
         cyc();
         if (k >= 7) begin
            total++;
            if (Level1_End !== (k == 8)) begin
               bad++; $display("FAIL areset_restart edge%0d: end=%b want %b", k, Level1_End, k == 8);
            end
         end
      end
      go_idle();
   endtask

   task automatic model_step();
      bit l_act, ok;
      l_act = (m_lvl == 1) ? Level1_Active : (m_lvl == 2) ? Level2_Active : Level3_Active;
      m_resp = 1'b0;
      case (m_state)
         0: if (Level1_Active || Level2_Active || Level3_Active) begin
            m_lvl = Level1_Active ? 1 : (Level2_Active ? 2 : 3);
            m_state = 1; m_goal = 0; m_coin = 1'b0;
         end
         1: if (!l_act) begin
            m_state = 0; m_goal = 0; m_coin = 1'b0;
         end else if (Player_Hit) begin
            m_state = 2; m_goal = 0; m_coin = 1'b0; m_dead = 0;
            if (m_deaths < 65535) m_deaths++;
         end else begin
            ok = (m_lvl == 1) || m_coin;
            if (PlayerX >= Goal_X0 && PlayerX <= Goal_X1 && PlayerY >= Goal_Y0 &&
                PlayerY <= Goal_Y1 && ok) m_goal++;
            else m_goal = 0;
            if (m_goal >= 8) m_state = 3;
            if (m_lvl != 1 && iabs(int'(PlayerX) - int'(Coin_X)) <= 8 &&
                iabs(int'(PlayerY) - int'(Coin_Y)) <= 8) m_coin = 1'b1;
         end
         2: if (!l_act) begin
            m_state = 0; m_goal = 0; m_coin = 1'b0;
         end else if (m_dead == 59) begin
            m_state = 1; m_resp = 1'b1;
         end else m_dead++;
         default: if (!l_act) begin
            m_state = 0; m_goal = 0; m_coin = 1'b0;
         end
      endcase
   endtask

   task automatic pick_geometry();
      int x0, y0;
      x0 = $urandom_range(0, 900);
      y0 = $urandom_range(0, 900);
      Goal_X0 = 10'(x0); Goal_X1 = 10'(x0 + $urandom_range(0, 60));
      Goal_Y0 = 10'(y0); Goal_Y1 = 10'(y0 + $urandom_range(0, 60));
      Coin_X = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 12)) : 10'($urandom_range(0, 1023));
      Coin_Y = 10'($urandom_range(0, 1023));
   endtask

   task automatic test_random();
      logic [5:0] exp_flags, got_flags;
      int shown;
      Reset_n = 1'b0;
      go_idle();
      Reset_n = 1'b1;
      m_state = 0; m_lvl = 1; m_goal = 0; m_dead = 0; m_deaths = 0; m_coin = 1'b0; m_resp = 1'b0;
      shown = 0;
      pick_geometry();
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 99) == 0) begin
            {Level3_Active, Level2_Active, Level1_Active} = 3'($urandom_range(0, 7));
         end
         if (m_state == 0 && $urandom_range(0, 3) == 0) pick_geometry();
         if ($urandom_range(0, 15) == 0) begin
            case ($urandom_range(0, 3))
               0: set_pos($urandom_range(int'(Goal_X0), int'(Goal_X1)),
                          $urandom_range(int'(Goal_Y0), int'(Goal_Y1)));
               1: begin
                  PlayerX = clamp10(int'(Coin_X) + $urandom_range(0, 20) - 10);
                  PlayerY = clamp10(int'(Coin_Y) + $urandom_range(0, 20) - 10);
               end
               2: set_pos($urandom_range(0, 1023), $urandom_range(0, 1023));
               default: begin
                  PlayerX = clamp10(int'(Goal_X1) + $urandom_range(0, 2) - 1);
                  PlayerY = clamp10(int'(Goal_Y0) + $urandom_range(0, 2) - 1);
               end
            endcase
         end
         Player_Hit = ($urandom_range(0, 79) == 0);
         model_step();
         cyc();
         exp_flags = {m_state == 3 && m_lvl == 1, m_state == 3 && m_lvl == 2,
                      m_state == 3 && m_lvl == 3, m_coin && m_lvl == 2, m_coin && m_lvl == 3, m_resp};
         got_flags = {Level1_End, Level2_End, Level3_End, CoinCollected_Level2,
                      CoinCollected_Level3, Respawn};
         total++;
         if (got_flags !== exp_flags || Death_Count !== 16'(m_deaths)) begin
            bad++;
            if (shown < 10) begin
               shown++;
               $display("FAIL random cyc%0d: flags=%b deaths=%0d want %b/%0d",
                        n, got_flags, Death_Count, exp_flags, m_deaths);
            end
         end
      end
      go_idle();
   endtask

   initial begin
      test_reset();
      test_l1_goal();
      test_l2_coin();
      test_coin_reach();
      test_hit();
      test_back_to_back();
      test_simultaneous();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
